// File: rtl/fifo_byte_reader_pkg.sv
// Shared widths, types and byte-lane helper for the capture FIFO byte reader.
package fifo_byte_reader_pkg;

   localparam int unsigned FIFO_DATA_W        = 18;
   localparam int unsigned FRB_BYTES_PER_WORD = 3;
   localparam int unsigned FRB_COUNT_W        = 16;
   localparam int unsigned FRB_BYTE_W         = 8;
   localparam int unsigned FRB_IDX_W          = 2;
   localparam int unsigned FRB_OCC_W          = 2;

   typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
   typedef logic [FRB_IDX_W-1:0]   byte_idx_t;

   localparam byte_idx_t                FRB_LAST_IDX  = byte_idx_t'(FRB_BYTES_PER_WORD - 1);
   localparam logic [FRB_COUNT_W-1:0]   FRB_COUNT_MAX = '1;
   localparam logic [FRB_OCC_W-1:0]     FRB_OCC_FULL  = FRB_OCC_W'(2);

   // Byte lane select: low byte first, top two data bits zero-extended last.
   function automatic logic [FRB_BYTE_W-1:0] word_byte(input fifo_word_t w, input byte_idx_t idx);
      logic [FRB_BYTE_W-1:0] b;
      b = '0;
      case (idx)
         byte_idx_t'(0): b = w[7:0];
         byte_idx_t'(1): b = w[15:8];
         default:        b = FRB_BYTE_W'(w[FIFO_DATA_W-1:16]);
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fifo_word_skid.sv
// Two-entry word buffer (cur/nxt): pop shifts nxt into cur, push fills the
// lowest free slot after any pop in the same cycle.
module fifo_word_skid
   import fifo_byte_reader_pkg::*;
(
   input  logic                 cwusb_clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 push,
   input  fifo_word_t           push_data,
   input  logic                 pop,
   output logic                 cur_valid,
   output fifo_word_t           cur_data_nx_c,
   output logic                 cur_valid_nx_c,
   output logic [FRB_OCC_W-1:0] occupancy_c
);

   fifo_word_t cur_q, nxt_q, cur_d, nxt_d;
   logic       cur_v_q, nxt_v_q, cur_v_d, nxt_v_d;

   // Next-state: clear dominates, otherwise pop first, then push into lowest free slot.
   always_comb begin
      cur_d   = cur_q;
      nxt_d   = nxt_q;
      cur_v_d = cur_v_q;
      nxt_v_d = nxt_v_q;
      if (clear) begin
         cur_v_d = 1'b0;
         nxt_v_d = 1'b0;
      end else begin
         if (pop && cur_v_q) begin
            cur_d   = nxt_q;
            cur_v_d = nxt_v_q;
            nxt_v_d = 1'b0;
         end
         if (push) begin
            if (!cur_v_d) begin
               cur_d   = push_data;
               cur_v_d = 1'b1;
            end else begin
               nxt_d   = push_data;
               nxt_v_d = 1'b1;
            end
         end
      end
   end

   // Buffer registers.
   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_q   <= '0;
         nxt_q   <= '0;
         cur_v_q <= 1'b0;
         nxt_v_q <= 1'b0;
      end else begin
         cur_q   <= cur_d;
         nxt_q   <= nxt_d;
         cur_v_q <= cur_v_d;
         nxt_v_q <= nxt_v_d;
      end
   end

   assign cur_valid      = cur_v_q;
   assign cur_data_nx_c  = cur_d;
   assign cur_valid_nx_c = cur_v_d;
   assign occupancy_c    = FRB_OCC_W'(cur_v_q) + FRB_OCC_W'(nxt_v_q);

endmodule

// File: rtl/fifo_byte_reader.sv
// Capture FIFO drain engine: issues spaced FIFO reads, prefetches up to two
// words and serialises each 18-bit word into three bytes for the host.
module fifo_byte_reader
   import fifo_byte_reader_pkg::*;
(
   input  logic                   cwusb_clk,
   input  logic                   reset_n,
   input  logic                   I_fifo_empty,
   input  logic [FIFO_DATA_W-1:0] I_fifo_data,
   output logic                   O_fifo_read,
   input  logic                   I_flush,
   input  logic                   I_byte_read,
   output logic [FRB_BYTE_W-1:0]  O_byte,
   output logic                   O_byte_valid,
   input  logic                   I_clear_flags,
   output logic                   O_underflow,
   output logic [FRB_COUNT_W-1:0] O_word_count
);

   logic                   rd_q, rd_d;
   logic                   inflight_q, inflight_d;
   logic                   drop_q, drop_d;
   byte_idx_t              idx_q, idx_d;
   logic [FRB_BYTE_W-1:0]  byte_q, byte_d;
   logic                   byte_valid_q, byte_valid_d;
   logic                   underflow_q, underflow_d;
   logic [FRB_COUNT_W-1:0] word_count_q, word_count_d;

   logic                   push_c, pop_c, consume_c;
   logic                   cur_valid;
   fifo_word_t             cur_data_nx_c;
   logic                   cur_valid_nx_c;
   logic [FRB_OCC_W-1:0]   occupancy_c;

   fifo_word_skid u_skid (
      .cwusb_clk      (cwusb_clk),
      .reset_n        (reset_n),
      .clear          (I_flush),
      .push           (push_c),
      .push_data      (I_fifo_data),
      .pop            (pop_c),
      .cur_valid      (cur_valid),
      .cur_data_nx_c  (cur_data_nx_c),
      .cur_valid_nx_c (cur_valid_nx_c),
      .occupancy_c    (occupancy_c)
   );

   // Read issue, capture/drop tracking, byte index, flags and output byte next-state.
   always_comb begin
      rd_d         = 1'b0;
      inflight_d   = rd_q;
      drop_d       = drop_q;
      idx_d        = idx_q;
      underflow_d  = underflow_q;
      word_count_d = word_count_q;
      push_c       = 1'b0;
      consume_c    = 1'b0;
      pop_c        = 1'b0;

      // Empty flag is stale right after a read, so never issue back to back.
      rd_d = !I_fifo_empty && !I_flush && !rd_q && !inflight_q &&
             (occupancy_c < FRB_OCC_FULL);

      // Word from the previous read lands this edge unless flushed away.
      push_c = inflight_q && !drop_q && !I_flush;

      // Drop marks the outstanding read's word; it retires on the capture edge.
      if (inflight_q) begin
         drop_d = 1'b0;
      end else if (I_flush && rd_q) begin
         drop_d = 1'b1;
      end

      consume_c = I_byte_read && cur_valid && !I_flush;
      pop_c     = consume_c && (idx_q == FRB_LAST_IDX);

      if (I_flush) begin
         idx_d = '0;
      end else if (consume_c) begin
         idx_d = pop_c ? '0 : idx_q + byte_idx_t'(1);
      end

      // Underflow set beats clear.
      if (I_byte_read && !cur_valid) begin
         underflow_d = 1'b1;
      end else if (I_clear_flags) begin
         underflow_d = 1'b0;
      end

      // A completion coincident with clear leaves a count of one.
      if (I_clear_flags) begin
         word_count_d = pop_c ? FRB_COUNT_W'(1) : '0;
      end else if (pop_c && (word_count_q != FRB_COUNT_MAX)) begin
         word_count_d = word_count_q + FRB_COUNT_W'(1);
      end

      byte_valid_d = cur_valid_nx_c;
      byte_d       = cur_valid_nx_c ? word_byte(cur_data_nx_c, idx_d) : '0;
   end

   // Control and output registers.
   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q         <= 1'b0;
         inflight_q   <= 1'b0;
         drop_q       <= 1'b0;
         idx_q        <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         underflow_q  <= 1'b0;
         word_count_q <= '0;
      end else begin
         rd_q         <= rd_d;
         inflight_q   <= inflight_d;
         drop_q       <= drop_d;
         idx_q        <= idx_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         underflow_q  <= underflow_d;
         word_count_q <= word_count_d;
      end
   end

   assign O_fifo_read  = rd_q;
   assign O_byte       = byte_q;
   assign O_byte_valid = byte_valid_q;
   assign O_underflow  = underflow_q;
   assign O_word_count = word_count_q;

endmodule
